// File: rtl/sio_pkg.sv
// rtl/sio_pkg.sv - shared serial IO link constants and TX framer state type
package sio_pkg;

  localparam int          SIO_NIBBLE_W    = 4;
  localparam int          SIO_CNT_W       = 4;
  localparam logic [3:0]  SIO_IDLE_NIBBLE = 4'hF;
  localparam logic        SIO_START_BIT   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sio_tx_state_t;

endpackage

// File: rtl/sio_tx_framer_if.sv
// rtl/sio_tx_framer_if.sv - write handshake and line-side signals of the TX framer
interface sio_tx_framer_if #(
  parameter int NB = 40
);
  import sio_pkg::*;

  logic                    wvalid;
  logic                    wready;
  logic [NB-1:0]           wdata;
  logic [SIO_NIBBLE_W-1:0] td;
  logic                    t;
  logic                    busy;
  logic                    frame_done;

  modport master (
    output wvalid, wdata,
    input  wready, td, t, busy, frame_done
  );

  modport slave (
    input  wvalid, wdata,
    output wready, td, t, busy, frame_done
  );

endinterface

// File: rtl/sio_tx_sr.sv
// rtl/sio_tx_sr.sv - start-bit/payload shift register with ones fill, registered nibble out
module sio_tx_sr
  import sio_pkg::*;
#(
  parameter int NB = 40
) (
  input  logic                    c,
  input  logic                    r,
  input  logic                    i_load,
  input  logic                    i_send,
  input  logic [NB-1:0]           i_data,
  output logic [SIO_NIBBLE_W-1:0] o_td
);

  logic [NB:0]             r_sr;
  logic [SIO_NIBBLE_W-1:0] r_td;

  // Present the top nibble while sending, idle ones otherwise; shift in ones every cycle
  always_ff @(posedge c) begin
    if (!r) begin
      r_sr <= '1;
      r_td <= SIO_IDLE_NIBBLE;
    end else begin
      r_td <= i_send ? r_sr[NB -: SIO_NIBBLE_W] : SIO_IDLE_NIBBLE;
      if (i_load) begin
        r_sr <= {SIO_START_BIT, i_data};
      end else begin
        r_sr <= {r_sr[NB-SIO_NIBBLE_W:0], SIO_IDLE_NIBBLE};
      end
    end
  end

  assign o_td = r_td;

endmodule

// File: rtl/sio_tx_framer.sv
// rtl/sio_tx_framer.sv - nibble-rate TX framer: holding register, lead-in, frame, gap
module sio_tx_framer
  import sio_pkg::*;
#(
  parameter int NB   = 40,
  parameter int LEAD = 2,
  parameter int GAP  = 3
) (
  input  logic           c,
  input  logic           r,
  sio_tx_framer_if.slave bus
);

  localparam logic [SIO_CNT_W-1:0] LEAD_LOAD = SIO_CNT_W'(LEAD - 1);
  localparam logic [SIO_CNT_W-1:0] GAP_LOAD  = SIO_CNT_W'(GAP - 1);
  localparam logic [SIO_CNT_W-1:0] SEND_LOAD = SIO_CNT_W'(NB / 4);

  sio_tx_state_t           r_state;
  logic [SIO_CNT_W-1:0]    r_cnt;
  logic                    r_hv;
  logic [NB-1:0]           r_hd;
  logic                    r_t;
  logic                    r_fd;
  logic                    w_xfer;
  logic                    w_load;
  logic                    w_send;
  logic                    w_cnt_zero;
  logic [SIO_NIBBLE_W-1:0] w_td;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_xfer     = bus.wvalid && bus.wready;
  // The holding word moves to the shifter at the end of lead-in, or straight out of a gap
  assign w_load     = ((r_state == ST_LEAD) && w_cnt_zero) ||
                      ((r_state == ST_GAP) && w_cnt_zero && r_hv);
  assign w_send     = (r_state == ST_SEND);

  // Outputs lag the state by one cycle; counters pace lead-in, frame and gap
  always_ff @(posedge c) begin
    if (!r) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hv    <= 1'b0;
      r_hd    <= '0;
      r_t     <= 1'b1;
      r_fd    <= 1'b0;
    end else begin
      r_t  <= (r_state == ST_IDLE);
      r_fd <= w_send && w_cnt_zero;
      case (r_state)
        ST_IDLE: begin
          if (r_hv) begin
            r_state <= ST_LEAD;
            r_cnt   <= LEAD_LOAD;
          end
        end
        ST_LEAD: begin
          if (w_cnt_zero) begin
            r_state <= ST_SEND;
            r_cnt   <= SEND_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (w_cnt_zero) begin
            r_state <= ST_GAP;
            r_cnt   <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (w_cnt_zero) begin
            if (r_hv) begin
              r_state <= ST_SEND;
              r_cnt   <= SEND_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_load) begin
        r_hv <= 1'b0;
      end
      if (w_xfer) begin
        r_hv <= 1'b1;
        r_hd <= bus.wdata;
      end
    end
  end

  sio_tx_sr #(.NB(NB)) u_sr (
    .c      (c),
    .r      (r),
    .i_load (w_load),
    .i_send (w_send),
    .i_data (r_hd),
    .o_td   (w_td)
  );

  assign bus.wready     = r && !r_hv;
  assign bus.busy       = (r_state != ST_IDLE) || r_hv;
  assign bus.td         = w_td;
  assign bus.t          = r_t;
  assign bus.frame_done = r_fd;

endmodule
